palette_mixer: RTL and testbench

// - Sits directly downstream of the tile-plane stage (k052109/k051962 pair).
// - Takes that stage's per-pixel layer codes (VA, VB, FX), the sprite pixel code and the blanking and sync signals.
// - Resolves layer priority, looks up the winning colour in an internal palette RAM and emits RGB888 with delayed sync.
// - The palette RAM is shared with the CPU through an 8-bit port with a DTACK-style handshake.

---
 rtl/palette_mixer_pkg.sv | 33 +++
 rtl/palette_mixer_prio.sv | 57 +++++
 rtl/ram_sim.sv | 22 ++
 rtl/palette_mixer.sv | 163 ++++++++++++++++
 tb/tb_palette_mixer.sv | 326 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/palette_mixer_pkg.sv
// Shared definitions for the palette mixer: pixel slot sequence, layer
// priority modes and small colour helpers.
package palette_mixer_pkg;

  // Four clk_main slots make up one 6 MHz pixel.
  typedef enum logic [1:0] {
    SLOT_SAMPLE = 2'd0,
    SLOT_VRAM   = 2'd1,
    SLOT_CPU    = 2'd2,
    SLOT_OUT    = 2'd3
  } slot_t;

  // Priority order among OBJ, A and B (FX always sits on top).
  typedef enum logic [1:0] {
    PRI_OBJ_A_B = 2'd0,
    PRI_A_OBJ_B = 2'd1,
    PRI_A_B_OBJ = 2'd2,
    PRI_OBJ_B_A = 2'd3
  } pri_t;

  localparam int unsigned PAL_IDX_W = 10;

  // Pen 0 is transparent on every layer.
  function automatic logic pen_zero(input logic [3:0] pen);
    return pen == 4'd0;
  endfunction

  // 5-bit channel to 8-bit by replicating the top bits into the LSBs.
  function automatic logic [7:0] expand5(input logic [4:0] c);
    return {c, c[4:2]};
  endfunction

endpackage

// File: rtl/palette_mixer_prio.sv
// Combinational layer priority resolver: picks the winning layer code and
// forms the 10-bit palette index.
module palette_prio
  import palette_mixer_pkg::*;
#(
  parameter int unsigned OBJ_W = 11
) (
  input  logic [11:0]          va,
  input  logic [11:0]          vb,
  input  logic [7:0]           fx,
  input  logic [OBJ_W-1:0]     ob,
  input  pri_t                 pri,
  output logic [PAL_IDX_W-1:0] idx
);

  logic a_op, b_op, o_op;
  logic unused_bits;

  // Colour bits above the 10-bit index and the shadow flag do not affect colour.
  assign unused_bits = ^{va[11:10], vb[11:10], ob[OBJ_W-1:10]};

  // FX on top, then the PRI-selected order; all-transparent falls back to VB.
  always_comb begin
    a_op = !pen_zero(va[3:0]);
    b_op = !pen_zero(vb[3:0]);
    o_op = !pen_zero(ob[3:0]);
    idx  = vb[9:0];
    if (!pen_zero(fx[3:0])) begin
      idx = {2'b00, fx};
    end else begin
      case (pri)
        PRI_OBJ_A_B: begin
          if (o_op)      idx = ob[9:0];
          else if (a_op) idx = va[9:0];
          else if (b_op) idx = vb[9:0];
        end
        PRI_A_OBJ_B: begin
          if (a_op)      idx = va[9:0];
          else if (o_op) idx = ob[9:0];
          else if (b_op) idx = vb[9:0];
        end
        PRI_A_B_OBJ: begin
          if (a_op)      idx = va[9:0];
          else if (b_op) idx = vb[9:0];
          else if (o_op) idx = ob[9:0];
        end
        PRI_OBJ_B_A: begin
          if (o_op)      idx = ob[9:0];
          else if (b_op) idx = vb[9:0];
          else if (a_op) idx = va[9:0];
        end
        default: idx = vb[9:0];
      endcase
    end
  end

endmodule

// File: rtl/ram_sim.sv
// Single-port byte-wide palette storage: synchronous write, asynchronous read.
module ram_sim #(
  parameter int unsigned AW = 10,
  parameter int unsigned DW = 8
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] addr,
  input  logic [DW-1:0] d,
  output logic [DW-1:0] q
);

  logic [DW-1:0] mem [0:(1 << AW) - 1];

  // Write port; contents are deliberately never reset.
  always_ff @(posedge clk) begin
    if (we) mem[addr] <= d;
  end

  assign q = mem[addr];

endmodule

// File: rtl/palette_mixer.sv
// Palette mixer: samples tile/sprite codes each pixel, resolves priority,
// reads the palette RAM and outputs RGB888 with matching sync. The CPU
// shares the RAM through a DTACK-style byte port in slot 2.
module palette_mixer
  import palette_mixer_pkg::*;
#(
  parameter int unsigned PAL_AW = 10,
  parameter int unsigned OBJ_W  = 11
) (
  input  logic              clk_main,
  input  logic              reset,
  input  logic              ce_pix,
  input  logic [11:0]       VA,
  input  logic [11:0]       VB,
  input  logic [7:0]        FX,
  input  logic [OBJ_W-1:0]  OB,
  input  logic              NCBLK,
  input  logic              SYNC,
  input  logic              cpu_cs,
  input  logic              cpu_rnw,
  input  logic [PAL_AW:0]   cpu_addr,
  input  logic [7:0]        DB_IN,
  input  logic              pri_we,
  output logic [7:0]        DB_OUT,
  output logic              pal_dtac,
  output logic [7:0]        R,
  output logic [7:0]        G,
  output logic [7:0]        B,
  output logic              SYNC_O
);

  slot_t slot_q, slot_d;
  logic  vram_slot, cpu_slot;

  pri_t             pri_q, pri_s;
  logic [11:0]      va_s, vb_s;
  logic [7:0]       fx_s;
  logic [OBJ_W-1:0] ob_s;
  logic             ncblk_s, sync_s;

  logic [PAL_IDX_W-1:0] vid_idx;
  logic [PAL_AW-1:0]    ram_addr;
  logic [7:0]           hi_q, lo_q;
  logic [15:0]          pix_word;
  logic                 cpu_go, we_hi, we_lo;
  logic                 unused_bits;

  assign unused_bits = pix_word[15];

  // Slot register.
  always_ff @(posedge clk_main or posedge reset) begin
    if (reset) slot_q <= SLOT_SAMPLE;
    else       slot_q <= slot_d;
  end

  // Restart on every pixel enable, otherwise advance and park in SLOT_OUT.
  always_comb begin
    slot_d = slot_q;
    if (ce_pix)                 slot_d = SLOT_SAMPLE;
    else if (slot_q != SLOT_OUT) slot_d = slot_t'(slot_q + 2'd1);
  end

  // Slot decode.
  always_comb begin
    vram_slot = (slot_q == SLOT_VRAM);
    cpu_slot  = (slot_q == SLOT_CPU);
  end

  // Priority mode register written by the CPU strobe.
  always_ff @(posedge clk_main or posedge reset) begin
    if (reset)       pri_q <= PRI_OBJ_A_B;
    else if (pri_we) pri_q <= pri_t'(DB_IN[1:0]);
  end

  // Per-pixel input sample; PRI is captured here so a mid-pixel change waits for the next pixel.
  always_ff @(posedge clk_main or posedge reset) begin
    if (reset) begin
      va_s    <= '0;
      vb_s    <= '0;
      fx_s    <= '0;
      ob_s    <= '0;
      ncblk_s <= 1'b0;
      sync_s  <= 1'b1;
      pri_s   <= PRI_OBJ_A_B;
    end else if (ce_pix) begin
      va_s    <= VA;
      vb_s    <= VB;
      fx_s    <= FX;
      ob_s    <= OB;
      ncblk_s <= NCBLK;
      sync_s  <= SYNC;
      pri_s   <= pri_q;
    end
  end

  palette_prio #(.OBJ_W(OBJ_W)) u_prio (
    .va  (va_s),
    .vb  (vb_s),
    .fx  (fx_s),
    .ob  (ob_s),
    .pri (pri_s),
    .idx (vid_idx)
  );

  // RAM port belongs to the CPU only in its slot; video owns it otherwise.
  always_comb begin
    cpu_go   = cpu_slot && cpu_cs && pal_dtac;
    we_hi    = cpu_go && !cpu_rnw && !cpu_addr[0];
    we_lo    = cpu_go && !cpu_rnw &&  cpu_addr[0];
    ram_addr = cpu_slot ? cpu_addr[PAL_AW:1] : PAL_AW'(vid_idx);
  end

  ram_sim #(.AW(PAL_AW), .DW(8)) u_ram_hi (
    .clk  (clk_main),
    .we   (we_hi),
    .addr (ram_addr),
    .d    (DB_IN),
    .q    (hi_q)
  );

  ram_sim #(.AW(PAL_AW), .DW(8)) u_ram_lo (
    .clk  (clk_main),
    .we   (we_lo),
    .addr (ram_addr),
    .d    (DB_IN),
    .q    (lo_q)
  );

  // Video word captured before the CPU slot, so a same-pixel write shows next pixel.
  always_ff @(posedge clk_main or posedge reset) begin
    if (reset)          pix_word <= '0;
    else if (vram_slot) pix_word <= {hi_q, lo_q};
  end

  // Colour and sync outputs advance once per pixel enable.
  always_ff @(posedge clk_main or posedge reset) begin
    if (reset) begin
      R      <= '0;
      G      <= '0;
      B      <= '0;
      SYNC_O <= 1'b1;
    end else if (ce_pix) begin
      R      <= ncblk_s ? expand5(pix_word[4:0])   : '0;
      G      <= ncblk_s ? expand5(pix_word[9:5])   : '0;
      B      <= ncblk_s ? expand5(pix_word[14:10]) : '0;
      SYNC_O <= sync_s;
    end
  end

  // CPU handshake: one access per select, acknowledge held until select drops.
  always_ff @(posedge clk_main or posedge reset) begin
    if (reset) begin
      pal_dtac <= 1'b1;
      DB_OUT   <= '0;
    end else if (cpu_go) begin
      pal_dtac <= 1'b0;
      if (cpu_rnw) DB_OUT <= cpu_addr[0] ? lo_q : hi_q;
    end else if (!pal_dtac && !cpu_cs) begin
      pal_dtac <= 1'b1;
    end
  end

endmodule

// File: tb/tb_palette_mixer.sv
// Self-checking bench for palette_mixer: a behavioural pixel model checked on
// every pixel plus directed literal checks of colour, CPU port and reset.
module tb_palette_mixer;

  localparam int unsigned PAL_AW = 10;
  localparam int unsigned OBJ_W  = 11;

  logic              clk_main = 1'b0;
  logic              reset;
  logic              ce_pix = 1'b0;
  logic [11:0]       VA, VB;
  logic [7:0]        FX;
  logic [OBJ_W-1:0]  OB;
  logic              NCBLK, SYNC, cpu_cs, cpu_rnw, pri_we;
  logic [PAL_AW:0]   cpu_addr;
  logic [7:0]        DB_IN;
  logic [7:0]        DB_OUT, R, G, B;
  logic              pal_dtac, SYNC_O;

  int n_cmp = 0;
  int n_bad = 0;

  palette_mixer #(.PAL_AW(PAL_AW), .OBJ_W(OBJ_W)) dut (
    .clk_main (clk_main),
    .reset    (reset),
    .ce_pix   (ce_pix),
    .VA       (VA),
    .VB       (VB),
    .FX       (FX),
    .OB       (OB),
    .NCBLK    (NCBLK),
    .SYNC     (SYNC),
    .cpu_cs   (cpu_cs),
    .cpu_rnw  (cpu_rnw),
    .cpu_addr (cpu_addr),
    .DB_IN    (DB_IN),
    .pri_we   (pri_we),
    .DB_OUT   (DB_OUT),
    .pal_dtac (pal_dtac),
    .R        (R),
    .G        (G),
    .B        (B),
    .SYNC_O   (SYNC_O)
  );

  always #5 clk_main = ~clk_main;

  // Pixel enable every 4th clock while running.
  bit ce_run = 1'b0;
  int ce_cnt = 0;
  always @(negedge clk_main) begin
    if (ce_run) begin
      ce_cnt++;
      ce_pix = (ce_cnt % 4 == 0);
    end else begin
      ce_pix = 1'b0;
    end
  end

  // ---------------- behavioural model ----------------
  logic [7:0] m_hi [1024];
  logic [7:0] m_lo [1024];
  bit         k_hi [1024];
  bit         k_lo [1024];
  int         m_pri;
  int         e_r, e_g, e_b, e_sync;
  bit         e_rgb_chk;
  bit         mon_en = 1'b0;
  int         ord [4][3] = '{'{0, 1, 2}, '{1, 0, 2}, '{1, 2, 0}, '{0, 2, 1}};

  function automatic int win_idx(int pri, int va, int vb, int fx, int ob);
    int code;
    if (fx % 16 != 0) return fx;
    for (int k = 0; k < 3; k++) begin
      case (ord[pri][k])
        0:       code = ob;
        1:       code = va;
        default: code = vb;
      endcase
      if (code % 16 != 0) return code % 1024;
    end
    return vb % 1024;
  endfunction

  function automatic int exp8(int c5);
    return c5 * 8 + c5 / 4;
  endfunction

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Each pixel enable: compare what the previous sample predicted, then predict this one.
  always @(posedge clk_main) begin
    if (ce_pix && !reset) begin
      int idx, w;
      #1;
      if (mon_en) begin
        check("pix_sync", int'(SYNC_O), e_sync);
        if (e_rgb_chk) begin
          check("pix_r", int'(R), e_r);
          check("pix_g", int'(G), e_g);
          check("pix_b", int'(B), e_b);
        end
      end
      idx    = win_idx(m_pri, int'(VA), int'(VB), int'(FX), int'(OB));
      e_sync = int'(SYNC);
      if (!NCBLK) begin
        e_r = 0; e_g = 0; e_b = 0; e_rgb_chk = 1'b1;
      end else if (k_hi[idx] && k_lo[idx]) begin
        w = int'({m_hi[idx], m_lo[idx]});
        e_r = exp8(w % 32);
        e_g = exp8((w / 32) % 32);
        e_b = exp8((w / 1024) % 32);
        e_rgb_chk = 1'b1;
      end else begin
        e_rgb_chk = 1'b0;
      end
    end
  end

  always @(posedge clk_main) begin
    if (pri_we && !reset) m_pri = int'(DB_IN[1:0]);
  end

  // ---------------- stimulus helpers ----------------
  task automatic model_reset();
    m_pri = 0; e_r = 0; e_g = 0; e_b = 0; e_sync = 1; e_rgb_chk = 1'b1;
  endtask

  task automatic wait_ce();
    for (int i = 0; i < 8; i++) begin
      @(posedge clk_main);
      if (ce_pix) return;
    end
    check("ce_timeout", 0, 1);
  endtask

  task automatic set_pri(input int p);
    wait_ce();
    @(negedge clk_main);
    pri_we = 1'b1; DB_IN = 8'(p);
    @(negedge clk_main);
    pri_we = 1'b0;
  endtask

  // Drive one pixel, then check the colour exactly 4 clocks after its sampling edge.
  task automatic px_test(input string name, input int va, input int vb, input int fx, input int ob,
                         input bit ncblk, input bit sync, input int er, input int eg, input int eb);
    @(negedge clk_main);
    VA = 12'(va); VB = 12'(vb); FX = 8'(fx); OB = 11'(ob); NCBLK = ncblk; SYNC = sync;
    wait_ce();
    repeat (4) @(posedge clk_main);
    #1;
    check({name, "_r"}, int'(R), er);
    check({name, "_g"}, int'(G), eg);
    check({name, "_b"}, int'(B), eb);
    check({name, "_sync"}, int'(SYNC_O), int'(sync));
  endtask

  task automatic cpu_xfer(input bit rnw, input int addr, input int wdata, output int rdata);
    int waited;
    bit got;
    @(negedge clk_main);
    cpu_cs = 1'b1; cpu_rnw = rnw; cpu_addr = 11'(addr); DB_IN = 8'(wdata);
    got = 1'b0; waited = 0; rdata = -1;
    for (int i = 1; i <= 12 && !got; i++) begin
      @(negedge clk_main);
      if (!pal_dtac) begin got = 1'b1; waited = i; end
    end
    if (!got) begin
      check("dtac_timeout", 0, 1);
    end else begin
      check("dtac_within_4", int'(waited <= 4), 1);
      if (!rnw) begin
        if (addr % 2 == 0) begin m_hi[addr / 2] = 8'(wdata); k_hi[addr / 2] = 1'b1; end
        else               begin m_lo[addr / 2] = 8'(wdata); k_lo[addr / 2] = 1'b1; end
      end
      rdata = int'(DB_OUT);
    end
    cpu_cs = 1'b0;
    @(negedge clk_main);
    check("dtac_rise", int'(pal_dtac), 1);
  endtask

  task automatic write_word(input int word, input int val);
    int dummy;
    cpu_xfer(1'b0, word * 2,     val / 256, dummy);
    cpu_xfer(1'b0, word * 2 + 1, val % 256, dummy);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- directed sequence ----------------
  initial begin
    int rd, sr, sg, sb, ss, falls, bad_hi;
    bit got;
    reset = 1'b1; VA = '0; VB = '0; FX = '0; OB = '0; NCBLK = 1'b0; SYNC = 1'b1;
    cpu_cs = 1'b0; cpu_rnw = 1'b1; cpu_addr = '0; DB_IN = '0; pri_we = 1'b0;
    model_reset();
    repeat (3) @(negedge clk_main);
    check("rst_r", int'(R), 0);
    check("rst_g", int'(G), 0);
    check("rst_b", int'(B), 0);
    check("rst_sync", int'(SYNC_O), 1);
    check("rst_dtac", int'(pal_dtac), 1);
    check("rst_dbout", int'(DB_OUT), 0);

    // Pin the model against hand-worked priority cases.
    check("model_fx",    win_idx(0, 12'h0A1, 12'h000, 8'h05, 11'h123), 10'h005);
    check("model_pri0",  win_idx(0, 12'h0A1, 12'h000, 8'h00, 11'h123), 10'h123);
    check("model_pri1",  win_idx(1, 12'h0A1, 12'h000, 8'h00, 11'h123), 10'h0A1);
    check("model_bdrop", win_idx(2, 12'h0A0, 12'h3F0, 8'h00, 11'h120), 10'h3F0);
    check("model_pri3",  win_idx(3, 12'h0A1, 12'h005, 8'h00, 11'h120), 10'h005);

    @(negedge clk_main);
    reset = 1'b0; ce_run = 1'b1; mon_en = 1'b1;
    repeat (6) @(negedge clk_main);
    check("run_dtac_idle", int'(pal_dtac), 1);

    write_word(10'h005, 16'h7C00);
    px_test("fx_blue", 12'h000, 12'h000, 8'h05, 11'h000, 1'b1, 1'b0, 8'h00, 8'h00, 8'hFF);

    write_word(10'h123, 16'h001F);
    write_word(10'h0A1, 16'h03E0);
    write_word(10'h3F0, 16'h5294);

    set_pri(0);
    px_test("pri0_obj", 12'h0A1, 12'h000, 8'h00, 11'h123, 1'b1, 1'b1, 8'hFF, 8'h00, 8'h00);
    set_pri(1);
    px_test("pri1_a",   12'h0A1, 12'h000, 8'h00, 11'h123, 1'b1, 1'b0, 8'h00, 8'hFF, 8'h00);
    px_test("backdrop", 12'h0A0, 12'h3F0, 8'h00, 11'h120, 1'b1, 1'b1, 8'hA5, 8'hA5, 8'hA5);
    px_test("blank",    12'h0A0, 12'h3F0, 8'h00, 11'h120, 1'b0, 1'b0, 8'h00, 8'h00, 8'h00);
    set_pri(3);
    px_test("pri3_b",   12'h0A1, 12'h005, 8'h00, 11'h120, 1'b1, 1'b1, 8'h00, 8'h00, 8'hFF);
    set_pri(2);
    px_test("pri2_obj", 12'h0A0, 12'h3F0, 8'h00, 11'h123, 1'b1, 1'b0, 8'hFF, 8'h00, 8'h00);

    // CPU reads while video runs.
    cpu_xfer(1'b1, 11'h7E1, 0, rd);
    check("rd_7e1", rd, 8'h94);
    cpu_xfer(1'b1, 11'h00B, 0, rd);
    check("rd_00b", rd, 8'h00);
    cpu_xfer(1'b1, 11'h00A, 0, rd);
    check("rd_00a", rd, 8'h7C);

    // Rewrite the entry on screen; the model decides which pixels see it.
    px_test("pre_coll", 12'h0A1, 12'h000, 8'h00, 11'h000, 1'b1, 1'b1, 8'h00, 8'hFF, 8'h00);
    cpu_xfer(1'b0, 11'h143, 8'h1F, rd);
    px_test("post_coll", 12'h0A1, 12'h000, 8'h00, 11'h000, 1'b1, 1'b0, 8'hFF, 8'hC6, 8'h00);

    // Missing pixel enables: outputs hold and the CPU waits.
    @(negedge clk_main);
    ce_run = 1'b0;
    repeat (6) @(negedge clk_main);
    sr = int'(R); sg = int'(G); sb = int'(B); ss = int'(SYNC_O);
    cpu_cs = 1'b1; cpu_rnw = 1'b1; cpu_addr = 11'h246;
    repeat (10) @(negedge clk_main);
    check("gap_no_service", int'(pal_dtac), 1);
    check("gap_hold_r", int'(R), sr);
    check("gap_hold_g", int'(G), sg);
    check("gap_hold_b", int'(B), sb);
    check("gap_hold_sync", int'(SYNC_O), ss);
    check("gap_hold_lit_g", int'(G), 8'hC6);
    ce_run = 1'b1;
    got = 1'b0;
    for (int i = 0; i < 12 && !got; i++) begin
      @(negedge clk_main);
      if (!pal_dtac) got = 1'b1;
    end
    check("gap_resume_ack", int'(got), 1);
    check("gap_resume_data", int'(DB_OUT), 8'h00);
    cpu_cs = 1'b0;
    @(negedge clk_main);
    check("gap_dtac_rise", int'(pal_dtac), 1);

    // Reset with a select pending: dropped, then serviced exactly once.
    @(negedge clk_main);
    cpu_cs = 1'b1; cpu_rnw = 1'b1; cpu_addr = 11'h00A;
    #1;
    reset = 1'b1;
    model_reset();
    #1;
    check("rst_cs_dtac", int'(pal_dtac), 1);
    check("rst_cs_r", int'(R), 0);
    check("rst_cs_sync", int'(SYNC_O), 1);
    repeat (3) @(negedge clk_main);
    check("rst_cs_dtac_hold", int'(pal_dtac), 1);
    check("rst_cs_dbout", int'(DB_OUT), 0);
    reset = 1'b0;
    got = 1'b0;
    for (int i = 0; i < 12 && !got; i++) begin
      @(negedge clk_main);
      if (!pal_dtac) got = 1'b1;
    end
    check("rst_cs_ack", int'(got), 1);
    check("rst_cs_data", int'(DB_OUT), 8'h7C);
    bad_hi = 0; falls = 0;
    repeat (10) begin
      @(negedge clk_main);
      if (pal_dtac) bad_hi++;
    end
    check("rst_cs_single", bad_hi, falls);
    cpu_cs = 1'b0;
    @(negedge clk_main);
    check("rst_cs_rise", int'(pal_dtac), 1);

    // A few more pixels after reset through the model, PRI back at 0.
    write_word(10'h123, 16'h001F);
    px_test("post_rst_pri0", 12'h0A1, 12'h000, 8'h00, 11'h123, 1'b1, 1'b1, 8'hFF, 8'h00, 8'h00);
    px_test("fx_pen8", 12'h0A1, 12'h000, 8'h08, 11'h123, 1'b0, 1'b0, 8'h00, 8'h00, 8'h00);
    repeat (12) @(negedge clk_main);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
